bram_stream_reader: RTL
=======================

// Module: bram_stream_reader
// PURPOSE
//  Read-side sequencer for the dual-port inferred BRAM. Drives its port B (en_b/addr_b).
//  Captures the 1-cycle-latency read data into a 2-entry output FIFO.
//  Presents that data as a valid/ready stream to the next pipeline stage.
//  One burst = start pulse + base address + length; done pulses after the last beat.
// PARAMETERS
//  DATA_WIDTH  16  word width, equal to the BRAM DATA_WIDTH
//  ADDR_WIDTH  10  BRAM address bits
//  LEN_WIDTH   11  burst length counter bits (max burst 2**LEN_WIDTH-1 words)
// PORTS
//  clk        in   1           single clock, rising edge
//  rst_n      in   1           asynchronous active-low reset
//  start      in   1           burst request, sampled only in IDLE
//  base_addr  in   ADDR_WIDTH  first BRAM address of the burst
//  length     in   LEN_WIDTH   number of words to read
//  busy       out  1           burst in progress
//  done       out  1           1-cycle pulse when the burst completes
//  en_b       out  1           BRAM port-B read enable
//  addr_b     out  ADDR_WIDTH  BRAM port-B address
//  dout_b     in   DATA_WIDTH  BRAM port-B data, valid 1 cycle after en_b
//  m_valid    out  1           output word valid
//  m_ready    in   1           downstream accepts the word
//  m_data     out  DATA_WIDTH  output word (FIFO head)
//  m_last     out  1           last word of the burst (RDR_LAST_EN builds only)
// BEHAVIOUR
//  - Reset: all outputs 0, FIFO empty, in-flight flag 0, FSM=IDLE.
//  - Reset is async assert, sync deassert; a mid-burst reset aborts the burst, no done pulse.
//  - FSM IDLE -> READ on start, capturing base_addr and length.
//  - start with length==0: IDLE -> DONE directly; no reads are issued.
//  - READ -> DRAIN after the final en_b is issued.
//  - DRAIN -> DONE when the FIFO is empty, no read is in flight, and the last beat handshakes.
//  - DONE -> IDLE unconditionally after 1 cycle.
//  - done=1 only in DONE. busy=1 in READ, DRAIN and DONE.
//  - start is ignored outside IDLE.
//  - Reads: en_b=1 in a READ cycle only when remaining>0 and (fifo_cnt + inflight - pop) < 2.
//    pop = m_valid & m_ready in that cycle. This rule guarantees the FIFO never overflows.
//  - addr_b increments by 1 per issued read and wraps modulo 2**ADDR_WIDTH (0x3FF -> 0x000).
//  - addr_b holds its value when en_b=0.
//  - inflight=1 in the cycle after en_b=1; dout_b is pushed into the FIFO at the end of that cycle.
//  - Simultaneous push and pop leave fifo_cnt unchanged. Data order is preserved.
//  - Latency: start at cycle 0 -> en_b at cycle 1 -> m_valid at cycle 3.
//  - With m_ready held 1, throughput is 1 word/cycle.
//  - Stream rule: once m_valid=1, m_valid and m_data stay stable until m_ready=1.
//  - m_data is driven from FIFO registers; it has no combinational path from dout_b.
// CONFIGURATION
//  - RDR_LAST_EN defined:
//    - each FIFO entry carries a last bit, set on the read whose remaining count was 1;
//    - m_last = head last bit & m_valid.
//  - RDR_LAST_EN undefined: port m_last is absent, and no last bit is stored.
//  - All other behaviour is identical in both builds.
// TESTING
//  1. Burst without backpressure:
//     - BRAM preloaded with mem[i]=i, start base=0x010, len=4, m_ready=1;
//     - required: data 0x10..0x13 on cycles 3..6, done pulse on cycle 7, busy low on cycle 8.
//  2. Burst with backpressure:
//     - len=8, m_ready toggled 1,0,0,1 repeating;
//     - required: all 8 words in order, none lost or duplicated;
//     - fifo_cnt never exceeds 2;
//     - m_data stable while m_valid=1 and m_ready=0.
//  3. Address wrap:
//     - base=0x3FE, len=4;
//     - required: addr_b sequence 0x3FE, 0x3FF, 0x000, 0x001.
//  4. Zero length:
//     - start with len=0;
//     - required: en_b and m_valid never asserted, done=1 exactly 1 cycle later.
//  5. Reset mid-burst:
//     - len=16, rst_n=0 at word 5;
//     - required: en_b=0 and m_valid=0 immediately, no done pulse;
//     - a new burst after reset starts clean.
//  6. RDR_LAST_EN build, len=3:
//     - required: m_last=1 only on the 3rd handshake.
//     - Also: start asserted while busy is ignored.

Source files
------------

// File: rtl/bram_stream_reader_if.sv
// ----------------------------------------------------------------------------
// bram_stream_reader_if
//   Valid/ready output stream of the BRAM stream reader.
//
//   Optional feature macro: RDR_LAST_EN adds the m_last end-of-burst marker.
//
//   Signals
//     m_valid  master -> slave  output word valid
//     m_ready  slave  -> master downstream accepts the word
//     m_data   master -> slave  output word
//     m_last   master -> slave  last word of the burst (RDR_LAST_EN only)
//
//   Modports
//     master   the reader (drives valid/data/last, samples ready)
//     slave    the downstream stage
// ----------------------------------------------------------------------------
interface bram_stream_reader_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
`ifdef RDR_LAST_EN
    logic                  m_last;
`endif

    modport master (
        input  m_ready,
`ifdef RDR_LAST_EN
        output m_last,
`endif
        output m_valid,
        output m_data
    );

    modport slave (
        output m_ready,
`ifdef RDR_LAST_EN
        input  m_last,
`endif
        input  m_valid,
        input  m_data
    );
endinterface

// File: rtl/bram_stream_reader.sv
// ----------------------------------------------------------------------------
// bram_stream_reader
//   Read-side sequencer for a dual-port inferred BRAM. A burst (start pulse,
//   base address, length) drives port B with one read per cycle as long as
//   the 2-entry output FIFO can absorb the 1-cycle-latency read data, and the
//   FIFO head is presented as a valid/ready stream. done pulses for one cycle
//   once the last word has been accepted downstream.
//
//   Optional feature macro: RDR_LAST_EN (adds m_last on the stream interface).
//
//   Ports
//     clk        in   single clock, rising edge
//     rst_n      in   asynchronous active-low reset; its deassertion is
//                     expected to be synchronised to clk upstream
//     start      in   burst request, sampled only while idle
//     base_addr  in   first BRAM address of the burst
//     length     in   number of words to read (0 = empty burst)
//     busy       out  burst in progress (READ, DRAIN, DONE)
//     done       out  1-cycle pulse when the burst completes
//     en_b       out  BRAM port-B read enable
//     addr_b     out  BRAM port-B address
//     dout_b     in   BRAM port-B read data, valid 1 cycle after en_b
//     m          --   output stream (bram_stream_reader_if.master)
// ----------------------------------------------------------------------------
module bram_stream_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic                  busy,
    output logic                  done,
    output logic                  en_b,
    output logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] dout_b,
    bram_stream_reader_if.master  m
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  remaining_q;
    logic                  inflight_q;     // a read issued last cycle returns now
    logic                  rd_en;

    logic [DATA_WIDTH-1:0] fifo_data [2];
    logic [1:0]            fifo_cnt_q;
    logic                  rd_ptr_q, wr_ptr_q;
    logic                  push, pop;
    logic [2:0]            occupancy;      // words held or arriving after this cycle

`ifdef RDR_LAST_EN
    logic                  fifo_last [2];
    logic                  inflight_last_q;
`endif

    assign push      = inflight_q;
    assign pop       = m.m_valid & m.m_ready;
    assign occupancy = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};

    // ------------------------------------------------------------------------
    // Next-state and read-issue logic
    // ------------------------------------------------------------------------
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (length == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                // Issue only if the word still fits once it lands next cycle.
                if (remaining_q != '0 && occupancy < 3'd2) begin
                    rd_en = 1'b1;
                    if (remaining_q == LEN_WIDTH'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Finish on the handshake that empties the FIFO for good.
                if (!inflight_q && fifo_cnt_q == 2'd1 && pop) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Sequencer state, address and length counters
    // ------------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking (<=) so every register samples the
    // pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= rd_en;
            if (state_q == S_IDLE && start) begin
                addr_q      <= base_addr;
                remaining_q <= length;
            end else if (rd_en) begin
                addr_q      <= addr_q + 1'b1;        // wraps at 2**ADDR_WIDTH
                remaining_q <= remaining_q - 1'b1;
            end
        end
    end

`ifdef RDR_LAST_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_last_q <= 1'b0;
        end else begin
            inflight_last_q <= rd_en && (remaining_q == LEN_WIDTH'(1));
        end
    end
`endif

    // ------------------------------------------------------------------------
    // 2-entry output FIFO
    // ------------------------------------------------------------------------
    // NOTE: the two data entries are reset so m_data reads 0 out of reset;
    // a deep storage array would normally be left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
`ifdef RDR_LAST_EN
            fifo_last[0] <= 1'b0;
            fifo_last[1] <= 1'b0;
`endif
            fifo_cnt_q   <= '0;
            rd_ptr_q     <= 1'b0;
            wr_ptr_q     <= 1'b0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr_q] <= dout_b;
`ifdef RDR_LAST_EN
                fifo_last[wr_ptr_q] <= inflight_last_q;
`endif
                wr_ptr_q            <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign en_b     = rd_en;
    assign addr_b   = addr_q;
    assign m.m_valid = (fifo_cnt_q != 2'd0);
    assign m.m_data  = fifo_data[rd_ptr_q];
`ifdef RDR_LAST_EN
    assign m.m_last  = fifo_last[rd_ptr_q] & m.m_valid;
`endif

endmodule
